// File: rtl/lm_sm_sequencer.sv
// lm_sm_sequencer
//   Multicycle LM/SM (load/store multiple) sequencer for the NITC-RISC24 core.
//   One start request moves a masked set of registers to or from consecutive
//   memory words, lowest register first. The controller stalls on busy and
//   resumes on the one-cycle done pulse.
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   start, is_store       request pulse (taken only in IDLE); 0=LM, 1=SM
//   base_addr, reg_mask   first address and register select mask, sampled with start
//   busy, done            in-flight indicator; one-cycle completion pulse
//   mem_addr/re/we/wdata  memory request; held stable until mem_ready
//   mem_rdata, mem_ready  memory response; a beat completes when mem_ready=1 in MEM
//   rf_ra, rf_rd          register read port (SM source, combinational)
//   rf_we, rf_wa, rf_wd   register write port (LM destination)
module lm_sm_sequencer #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int NREGS     = 8,
  parameter int ADDR_STEP = 1,
  localparam int IDX_W    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_store,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [NREGS-1:0]  reg_mask,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [IDX_W-1:0]  rf_ra,
  input  logic [DATA_W-1:0] rf_rd,
  output logic              rf_we,
  output logic [IDX_W-1:0]  rf_wa,
  output logic [DATA_W-1:0] rf_wd
);

  typedef enum logic [1:0] {IDLE, MEM, WB, DONE} state_t;

  // Request context latched at start and walked down as beats complete.
  typedef struct packed {
    logic              is_store;
    logic [ADDR_W-1:0] addr;
    logic [NREGS-1:0]  mask;
  } ctx_t;

  state_t            state, state_nxt;
  ctx_t              ctx;
  logic [DATA_W-1:0] ld_data;
  logic [IDX_W-1:0]  idx;
  logic [NREGS-1:0]  mask_rest;
  logic              advance;

  // Lowest set bit wins: scan high to low so the last hit is the lowest.
  always_comb begin
    idx = '0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (ctx.mask[i]) idx = IDX_W'(i);
    end
  end

  // Clearing the lowest set bit is the same as clearing mask[idx].
  assign mask_rest = ctx.mask & (ctx.mask - NREGS'(1));

  // A register slot is consumed at the end of WB (LM) or on an acked SM beat.
  assign advance = (state == WB) ||
                   ((state == MEM) && mem_ready && ctx.is_store);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ctx     <= '0;
      ld_data <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && start) begin
        ctx.is_store <= is_store;
        ctx.addr     <= base_addr;
        ctx.mask     <= reg_mask;
      end
      if ((state == MEM) && mem_ready && !ctx.is_store)
        ld_data <= mem_rdata;
      if (advance) begin
        ctx.mask <= mask_rest;
        ctx.addr <= ctx.addr + ADDR_W'(ADDR_STEP);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = (reg_mask != '0) ? MEM : DONE;
      MEM: begin
        if (mem_ready) begin
          if (!ctx.is_store)        state_nxt = WB;
          else if (mask_rest != '0) state_nxt = MEM;
          else                      state_nxt = DONE;
        end
      end
      WB:      state_nxt = (mask_rest != '0) ? MEM : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode from registered state only, so reset zeroes them at once.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_addr  = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    rf_ra     = '0;
    rf_we     = 1'b0;
    rf_wa     = '0;
    rf_wd     = '0;
    unique case (state)
      MEM: begin
        busy     = 1'b1;
        mem_addr = ctx.addr;
        if (ctx.is_store) begin
          mem_we    = 1'b1;
          rf_ra     = idx;
          mem_wdata = rf_rd;
        end else begin
          mem_re = 1'b1;
        end
      end
      WB: begin
        busy  = 1'b1;
        rf_wa = idx;
        rf_wd = ld_data;
        // R0 is the PC and belongs to the regfile: its slot is read but not written.
        rf_we = (idx != '0);
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule
